// File: rtl/seg_text_receiver.sv
// Receiver for the scrolling-text 7-segment link: synchronizes and debounces the
// remote digit-0 pattern, decodes each new glyph to ASCII and queues it for a consumer.
module seg_text_receiver #(
  parameter int STABLE_CYCLES = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic [3:0] an_in,
  output logic [7:0] char_code,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       msg_end,
  output logic [4:0] sym_count,
  output logic       err_unknown,
  output logic       overflow
);

  localparam int           AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [6:0]   BLANK    = 7'h7F;
  localparam logic [7:0]   CNT_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0]   CNT_PRE  = 8'(STABLE_CYCLES - 2);
  localparam logic [7:0]   UNKNOWN  = 8'h3F;
  localparam logic [AW:0]  CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]  CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Only the digit-0 anode carries the scrolling glyph.
  logic unused_an;
  assign unused_an = ^an_in[3:1];

  logic [6:0] seg_s1_reg, seg_s2_reg;
  logic       an_s1_reg, an_s2_reg;
  logic [6:0] eff_pat;
  logic [6:0] cand_reg;
  logic [7:0] cnt_reg;
  logic       acc_reg;
  logic [6:0] acc_pat_reg;
  logic [6:0] last_reg;
  logic       push_reg;
  logic [7:0] push_data_reg;
  logic [7:0] dec_char;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          pop, wr_en, full;

  function automatic logic [7:0] decode(input logic [6:0] p);
    case (p)
      7'b1000001: decode = 8'h55; // U
      7'b0001000: decode = 8'h41; // A
      7'b0000011: decode = 8'h42; // B
      7'b1000110: decode = 8'h43; // C
      7'b0111111: decode = 8'h2D; // -
      7'b0000110: decode = 8'h45; // E
      7'b1000111: decode = 8'h4C; // L
      7'b1001110: decode = 8'h54; // T
      7'b0101111: decode = 8'h52; // R
      7'b1000000: decode = 8'h4F; // O
      7'b0101011: decode = 8'h4E; // N
      7'b1001111: decode = 8'h49; // I
      default:    decode = UNKNOWN;
    endcase
  endfunction

  // A dark digit (anode off) reads as the blank glyph.
  assign eff_pat  = an_s2_reg ? BLANK : seg_s2_reg;
  assign dec_char = decode(acc_pat_reg);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_s1_reg  <= BLANK;
      seg_s2_reg  <= BLANK;
      an_s1_reg   <= 1'b1;
      an_s2_reg   <= 1'b1;
      cand_reg    <= BLANK;
      cnt_reg     <= 8'd0;
      acc_reg     <= 1'b0;
      acc_pat_reg <= BLANK;
    end else begin
      seg_s1_reg <= seg_in;
      seg_s2_reg <= seg_s1_reg;
      an_s1_reg  <= an_in[0];
      an_s2_reg  <= an_s1_reg;
      acc_reg    <= 1'b0;
      if (eff_pat != cand_reg) begin
        cand_reg <= eff_pat;
        cnt_reg  <= 8'd0;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 8'd1;
        // Saturation at CNT_MAX makes this fire once per stable run.
        if (cnt_reg == CNT_PRE) begin
          acc_reg     <= 1'b1;
          acc_pat_reg <= cand_reg;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg      <= BLANK;
      push_reg      <= 1'b0;
      push_data_reg <= 8'h00;
      msg_end       <= 1'b0;
      sym_count     <= 5'd0;
      err_unknown   <= 1'b0;
    end else begin
      push_reg <= 1'b0;
      msg_end  <= 1'b0;
      if (acc_reg && (acc_pat_reg != last_reg)) begin
        last_reg <= acc_pat_reg;
        if (acc_pat_reg == BLANK) begin
          if (sym_count != 5'd0) begin
            msg_end   <= 1'b1;
            sym_count <= 5'd0;
          end
        end else begin
          push_reg      <= 1'b1;
          push_data_reg <= dec_char;
          if (dec_char == UNKNOWN) err_unknown <= 1'b1;
          if (sym_count != 5'd31) sym_count <= sym_count + 5'd1;
        end
      end
    end
  end

  assign char_valid = (count_reg != '0);
  assign full       = (count_reg == CNT_FULL);
  assign pop        = char_valid && char_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign wr_en      = push_reg && (!full || pop);
  assign char_code  = char_valid ? mem[rd_ptr_reg] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg] <= push_data_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      if (wr_en && !pop)      count_reg <= count_reg + CNT_ONE;
      else if (!wr_en && pop) count_reg <= count_reg - CNT_ONE;
      if (push_reg && !wr_en) overflow <= 1'b1;
    end
  end

endmodule

// File: doc/seg_text_receiver.md
Name: seg_text_receiver

Overview:
- Receiving end of the UABC scrolling-text display link.
- Samples a remote board's active-low 7-segment lines and digit-0 anode, filters glitches, and decodes each newly displayed glyph to ASCII.
- Queues the decoded characters in a small FIFO with a valid/ready output handshake.
- Reports message boundaries (blank glyph), symbol count and error/overflow flags; sits between the ui_in pins and a downstream consumer or check logic.

Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a pattern is accepted (range 2..255).
- FIFO_DEPTH, 4: character FIFO entries; power of 2, range 2..16.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-low
- seg_in  input  7  segment lines, active-low; bit0=a … bit6=g (U = 7'b1000001)
- an_in  input  4  anode lines, active-low; only an_in[0] is used
- char_code  output  8  ASCII of FIFO head
- char_valid  output  1  FIFO non-empty
- char_ready  input  1  consumer accepts head when high with char_valid
- msg_end  output  1  one-cycle pulse at message boundary
- sym_count  output  5  letters received since last boundary, saturating at 31
- err_unknown  output  1  sticky; an unrecognized pattern was accepted
- overflow  output  1  sticky; a push was dropped because the FIFO was full

Behaviour:
- Reset, synchronous on rst_n=0: FIFO empty, char_valid=0, char_code=8'h00, msg_end=0, sym_count=0, err_unknown=0, overflow=0, filter counter=0, last-accepted pattern=7'h7F (blank).
- Input conditioning: seg_in and an_in[0] pass through a 2-FF synchronizer. Effective pattern = synced seg when synced an[0]=0; otherwise 7'h7F.
- Glitch filter: a candidate register holds the effective pattern.
  - If the effective pattern differs from the candidate, load the candidate and clear the counter.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
  - On the cycle the counter reaches STABLE_CYCLES-1, the candidate is accepted exactly once.
- Event rule: an accepted pattern equal to the last-accepted pattern produces no event. Consequence: a repeated letter is only re-recognized after an intervening different pattern.
- Letter event (accepted pattern ≠ blank, ≠ last-accepted):
  - Decode to ASCII and push to the FIFO on the next cycle.
  - sym_count increments, saturating at 31.
  - Update last-accepted.
- Blank event (accepted 7'h7F ≠ last-accepted):
  - No push.
  - If sym_count>0: msg_end pulses high for 1 cycle and sym_count clears. If sym_count=0: neither happens.
- Decode table (7-bit pattern → ASCII):
  - 1000001 → U (0x55)
  - 0001000 → A (0x41)
  - 0000011 → B (0x42)
  - 1000110 → C (0x43)
  - 0111111 → - (0x2D)
  - 0000110 → E (0x45)
  - 1000111 → L (0x4C)
  - 1001110 → T (0x54)
  - 0101111 → R (0x52)
  - 1000000 → O (0x4F)
  - 0101011 → N (0x4E)
  - 1001111 → I (0x49)
  - Any other non-blank pattern → '?' (0x3F), is still pushed, and sets err_unknown.
- Latency: a stable pattern change presented on seg_in before clock edge 0 raises char_valid after edge STABLE_CYCLES+3 (2 sync + STABLE_CYCLES filter + 1 push). There is no bypass: a push into an empty FIFO shows char_valid on the following cycle.
- FIFO behaviour:
  - char_code is the head entry, or 8'h00 when empty.
  - A pop occurs on a cycle with char_valid && char_ready.
  - Push while full without a simultaneous pop: the character is dropped, overflow is set, and sym_count still increments.
  - Push and pop in the same cycle: both occur at any occupancy, including full; no overflow.
  - Pointers wrap modulo FIFO_DEPTH; the count is held with one extra bit.
- Sticky flags clear only on reset.
- Reset asserted mid-filter or mid-message discards all state. The first accepted letter after reset is always recognized, because last-accepted resets to blank.

Test Plan:
- STABLE_CYCLES=4, char_ready=1; drive U, A, B, C, each held 20 cycles, an_in=4'b1110 → pops 0x55,0x41,0x42,0x43 in order; first char_valid exactly 7 edges after first seg_in change; sym_count=4.
- Then drive 7'h7F for 20 cycles → exactly one msg_end pulse; sym_count→0. Hold a second blank → no further pulse.
- Pattern E with 3-cycle glitches to 7'b0000000 between stable windows, plus an_in=4'b1111 for 20 cycles (blank) → only stable letters pushed; an_in high counted as a blank event.
- char_ready=0; push 6 distinct letters with FIFO_DEPTH=4 → 4 entries retained in order; overflow=1; sym_count=6. Then ready=1 → exactly 4 pops.
- Full FIFO with simultaneous push and pop → occupancy stays 4; overflow unchanged; order preserved.
- Pattern 7'b0010010 stable → 0x3F popped; err_unknown=1 until rst_n=0 is held one cycle, after which all outputs return to reset values.
